// File: rtl/key_arb_pkg.sv
// Shared constants and helpers for the key event arbiter.
package key_arb_pkg;

    localparam int unsigned KEY_N_DEFAULT     = 4;
    localparam int unsigned EVT_DEPTH_DEFAULT = 4;
    localparam int unsigned DROP_CNT_W        = 8;

    function automatic int unsigned code_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// Event FIFO: synchronous push/pop with registered head, async active-high reset.
module key_evt_fifo
    import key_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = EVT_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Storage is cleared on reset so the head reads as zero while empty after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/key_event_arbiter.sv
// Round-robin arbiter turning key press pulses into a queue of key-index events.
// Optional KEY_ARB_DROPCNT_EN adds a saturating dropped-press counter output drop_cnt.
module key_event_arbiter
    import key_arb_pkg::*;
#(
    parameter int unsigned N     = KEY_N_DEFAULT,
    parameter int unsigned DEPTH = EVT_DEPTH_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N-1:0]              key_pulse,
    input  logic                      evt_ready,
    input  logic                      ovf_clr,
    output logic                      evt_valid,
    output logic [code_w(N)-1:0]      evt_code,
    output logic [$clog2(DEPTH):0]    evt_count,
    output logic                      ovf
`ifdef KEY_ARB_DROPCNT_EN
    ,
    output logic [DROP_CNT_W-1:0]     drop_cnt
`endif
);

    localparam int unsigned CW = code_w(N);

    logic [N-1:0]  pending_q, pending_d;
    logic [N-1:0]  grant_oh, drop;
    logic [CW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] grant_idx;
    logic          grant_vld;
    logic          ovf_q, ovf_d;
    logic          fifo_full, fifo_empty;
    int unsigned   rr_idx;

    // Search upward from ptr, wrapping mod N; first pending key wins.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        rr_idx    = 0;
        for (int unsigned k = 0; k < N; k++) begin
            rr_idx = (int'(ptr_q) + k) % N;
            if (!grant_vld && !fifo_full && pending_q[rr_idx]) begin
                grant_vld        = 1'b1;
                grant_oh[rr_idx] = 1'b1;
                grant_idx        = CW'(rr_idx);
            end
        end
    end

    always_comb begin
        drop      = key_pulse & pending_q & ~grant_oh;
        pending_d = (pending_q & ~grant_oh) | key_pulse;
        ptr_d     = ptr_q;
        if (grant_vld) begin
            ptr_d = (int'(grant_idx) == N - 1) ? '0 : grant_idx + CW'(1);
        end
        ovf_d = ovf_q;
        if (|drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            ptr_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            ovf_q     <= ovf_d;
        end
    end

    assign ovf       = ovf_q;
    assign evt_valid = ~fifo_empty;

    key_evt_fifo #(
        .WIDTH (CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (grant_vld),
        .push_data (grant_idx),
        .pop       (evt_ready),
        .head      (evt_code),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (evt_count)
    );

`ifdef KEY_ARB_DROPCNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [DROP_CNT_W:0]   drop_acc;

    // Clear applies first, so drops in the clearing cycle are still counted.
    always_comb begin
        drop_acc = ovf_clr ? '0 : {1'b0, drop_cnt_q};
        for (int unsigned i = 0; i < N; i++) begin
            drop_acc = drop_acc + (DROP_CNT_W + 1)'(drop[i]);
        end
        drop_cnt_d = (drop_acc > (DROP_CNT_W + 1)'({DROP_CNT_W{1'b1}})) ? '1
                                                                         : drop_acc[DROP_CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_key_event_arbiter.sv
// Self-checking bench for key_event_arbiter: directed scenarios plus randomized traffic vs a model.
module tb_key_event_arbiter;

    localparam int N     = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_pulse;
    logic       evt_ready;
    logic       ovf_clr;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic [2:0] evt_count;
    logic       ovf;
`ifdef KEY_ARB_DROPCNT_EN
    logic [7:0] drop_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state: pending presses, search start, event queue, sticky flag.
    bit [3:0] m_pend;
    int       m_ptr;
    int       m_q[$];
    bit       m_ovf;
    int       m_drops;

    always #5 clk = ~clk;

    key_event_arbiter #(
        .N     (N),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_pulse (key_pulse),
        .evt_ready (evt_ready),
        .ovf_clr   (ovf_clr),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .evt_count (evt_count),
        .ovf       (ovf)
`ifdef KEY_ARB_DROPCNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    task automatic model_reset();
        m_pend  = '0;
        m_ptr   = 0;
        m_q.delete();
        m_ovf   = 1'b0;
        m_drops = 0;
    endtask

    task automatic model_edge(input bit [3:0] p, input bit r, input bit c);
        int g = -1;
        bit [3:0] gm = '0;
        int nd = 0;
        bit do_pop;
        do_pop = (m_q.size() > 0) && r;
        if (m_q.size() < DEPTH) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        if (g >= 0) gm[g] = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (p[i] && m_pend[i] && !gm[i]) nd++;
        end
        m_pend = (m_pend & ~gm) | p;
        if (do_pop) void'(m_q.pop_front());
        if (g >= 0) begin
            m_q.push_back(g);
            m_ptr = (g + 1) % N;
        end
        if (nd > 0) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
        if (c) m_drops = 0;
        m_drops = (m_drops + nd > 255) ? 255 : m_drops + nd;
    endtask

    // Drive one cycle of inputs, advance the model at the edge, return at the next falling edge.
    task automatic step(input bit [3:0] p, input bit r, input bit c);
        key_pulse = p;
        evt_ready = r;
        ovf_clr   = c;
        @(posedge clk);
        model_edge(p, r, c);
        @(negedge clk);
        key_pulse = '0;
        ovf_clr   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        key_pulse = '0;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        key_pulse = 4'b1111;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", evt_valid); end
        total++; if (evt_count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", evt_count); end
        total++; if (evt_code !== 2'd0) begin bad++; $display("FAIL reset_code: got %0d want 0", evt_code); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        key_pulse = '0;
        rst       = 1'b0;
        step(4'b0000, 1'b1, 1'b0);
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL reset_pulses_ignored: got %b want 0", evt_valid); end
    endtask

    task automatic test_single_press();
        do_reset();
        step(4'b0100, 1'b0, 1'b0);
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL single_early: got %b want 0", evt_valid); end
        step(4'b0000, 1'b0, 1'b0);
        total++; if (evt_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", evt_valid); end
        total++; if (evt_code !== 2'd2) begin bad++; $display("FAIL single_code: got %0d want 2", evt_code); end
        total++; if (evt_count !== 3'd1) begin bad++; $display("FAIL single_count: got %0d want 1", evt_count); end
        step(4'b0000, 1'b1, 1'b0);
        total++; if (evt_count !== 3'd0) begin bad++; $display("FAIL single_pop: got %0d want 0", evt_count); end
    endtask

    task automatic test_simultaneous();
        bit [1:0] exp_codes [3];
        exp_codes[0] = 2'd0; exp_codes[1] = 2'd1; exp_codes[2] = 2'd3;
        do_reset();
        step(4'b1011, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(4'b0000, 1'b1, 1'b0);
            total++;
            if (evt_valid !== 1'b1 || evt_code !== exp_codes[i]) begin
                bad++;
                $display("FAIL simul_code%0d: got valid=%b code=%0d want valid=1 code=%0d",
                         i, evt_valid, evt_code, exp_codes[i]);
            end
        end
        step(4'b0000, 1'b1, 1'b0);
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL simul_drain: got %b want 0", evt_valid); end
        // ptr must have wrapped to 0: an all-keys press starts at key 0
        step(4'b1111, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        total++; if (evt_code !== 2'd0) begin bad++; $display("FAIL simul_ptr_wrap: got %0d want 0", evt_code); end
    endtask

    task automatic test_full_fifo();
        do_reset();
        step(4'b1111, 1'b0, 1'b0);
        repeat (4) step(4'b0000, 1'b0, 1'b0);
        total++; if (evt_count !== 3'd4) begin bad++; $display("FAIL full_count: got %0d want 4", evt_count); end
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        total++; if (evt_count !== 3'd4) begin bad++; $display("FAIL full_nogrant: got %0d want 4", evt_count); end
        step(4'b0000, 1'b1, 1'b0);
        total++; if (evt_count !== 3'd3) begin bad++; $display("FAIL full_pop: got %0d want 3", evt_count); end
        step(4'b0000, 1'b0, 1'b0);
        total++; if (evt_count !== 3'd4) begin bad++; $display("FAIL full_refill: got %0d want 4", evt_count); end
        repeat (3) step(4'b0000, 1'b1, 1'b0);
        total++;
        if (evt_code !== 2'd1 || evt_count !== 3'd1) begin
            bad++;
            $display("FAIL full_late_code: got code=%0d count=%0d want code=1 count=1", evt_code, evt_count);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        step(4'b1111, 1'b0, 1'b0);
        repeat (4) step(4'b0000, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 1'b0);
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_first_press: got %b want 0", ovf); end
        step(4'b0100, 1'b0, 1'b0);
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", ovf); end
`ifdef KEY_ARB_DROPCNT_EN
        total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL ovf_dropcnt: got %0d want 1", drop_cnt); end
`endif
        step(4'b0000, 1'b0, 1'b0);
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
        step(4'b0000, 1'b0, 1'b1);
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", ovf); end
        step(4'b0100, 1'b0, 1'b1);
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_set_wins: got %b want 1", ovf); end
    endtask

    task automatic test_coincident();
        do_reset();
        step(4'b0001, 1'b1, 1'b0);
        step(4'b0001, 1'b1, 1'b0);
        total++;
        if (evt_valid !== 1'b1 || evt_code !== 2'd0) begin
            bad++;
            $display("FAIL coinc_first: got valid=%b code=%0d want valid=1 code=0", evt_valid, evt_code);
        end
        step(4'b0000, 1'b1, 1'b0);
        total++;
        if (evt_valid !== 1'b1 || evt_code !== 2'd0 || evt_count !== 3'd1) begin
            bad++;
            $display("FAIL coinc_second: got valid=%b code=%0d count=%0d want 1/0/1",
                     evt_valid, evt_code, evt_count);
        end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL coinc_ovf: got %b want 0", ovf); end
        step(4'b0000, 1'b1, 1'b0);
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL coinc_drain: got %b want 0", evt_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(4'b0111, 1'b0, 1'b0);
        repeat (3) step(4'b0000, 1'b0, 1'b0);
        total++; if (evt_count !== 3'd3) begin bad++; $display("FAIL mid_queued: got %0d want 3", evt_count); end
        rst       = 1'b1;
        key_pulse = 4'b1111;
        model_reset();
        #1;
        total++;
        if (evt_valid !== 1'b0 || evt_count !== 3'd0) begin
            bad++;
            $display("FAIL mid_async: got valid=%b count=%0d want 0/0", evt_valid, evt_count);
        end
        @(posedge clk);
        @(negedge clk);
        key_pulse = '0;
        rst       = 1'b0;
        step(4'b0000, 1'b1, 1'b0);
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL mid_discard: got %b want 0", evt_valid); end
        step(4'b1010, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        total++; if (evt_code !== 2'd1) begin bad++; $display("FAIL mid_rr_first: got %0d want 1", evt_code); end
        step(4'b0000, 1'b1, 1'b0);
        total++; if (evt_code !== 2'd3) begin bad++; $display("FAIL mid_rr_second: got %0d want 3", evt_code); end
    endtask

    task automatic test_random();
        bit [3:0] p;
        bit       r;
        bit       c;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            p = 4'($urandom & $urandom);
            r = (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 15) == 0);
            step(p, r, c);
            total++;
            if (evt_valid !== (m_q.size() > 0) || evt_count !== 3'(m_q.size()) || ovf !== m_ovf) begin
                bad++;
                $display("FAIL rand_state cyc%0d: got valid=%b count=%0d ovf=%b want %b/%0d/%b",
                         i, evt_valid, evt_count, ovf, m_q.size() > 0, m_q.size(), m_ovf);
            end
            if (m_q.size() > 0) begin
                total++;
                if (evt_code !== 2'(m_q[0])) begin
                    bad++;
                    $display("FAIL rand_code cyc%0d: got %0d want %0d", i, evt_code, m_q[0]);
                end
            end
`ifdef KEY_ARB_DROPCNT_EN
            total++;
            if (drop_cnt !== 8'(m_drops)) begin
                bad++;
                $display("FAIL rand_dropcnt cyc%0d: got %0d want %0d", i, drop_cnt, m_drops);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_simultaneous();
        test_full_fifo();
        test_overflow();
        test_coincident();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
